// File: rtl/db_arbiter.sv
// rtl/db_arbiter.sv - round-robin arbiter sharing the CPU data-break channel between DMA engines
// Optional BREQ watchdog enabled by defining DB_TIMEOUT_EN.
module db_arbiter #(
    parameter int         NREQ       = 2,
    parameter logic [4:0] DB1_CODE   = 5'd0,
    parameter int         DB_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [4:0]         state,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*15-1:0] req_addr,
    input  logic [NREQ*12-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic [11:0]        rd_data,
    output logic               data_break,
    output logic               to_disk,
    output logic [14:0]        dmaAddr,
    output logic [11:0]        dmaDOUT,
    input  logic [11:0]        dmaDIN,
    output logic               busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BREQ, S_CAPT, S_FIN} fsm_t;

    fsm_t          fsm;
    logic [IW-1:0] rr;
    logic [IW-1:0] w;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [14:0]   addr_a [NREQ];
    logic [11:0]   wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*15 +: 15];
        assign wdata_a[g] = req_wdata[g*12 +: 12];
    end

    // First set request scanning upward from rr, wrapping modulo NREQ.
    always_comb begin
        int j;
        j       = 0;
        win     = rr;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!win_vld && req[IW'(j)]) begin
                win     = IW'(j);
                win_vld = 1'b1;
            end
        end
    end

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        return (int'(x) == NREQ - 1) ? '0 : x + 1'b1;
    endfunction

    assign busy = (fsm != S_IDLE);

`ifdef DB_TIMEOUT_EN
    localparam int TW = ($clog2(DB_TIMEOUT + 1) > 10) ? $clog2(DB_TIMEOUT + 1) : 10;
    logic [TW-1:0]   tmo_cnt;
    logic [NREQ-1:0] err_q;
    assign err = err_q;
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= S_IDLE;
            rr         <= '0;
            w          <= '0;
            done       <= '0;
            rd_data    <= '0;
            data_break <= 1'b0;
            to_disk    <= 1'b0;
            dmaAddr    <= '0;
            dmaDOUT    <= '0;
`ifdef DB_TIMEOUT_EN
            err_q      <= '0;
            tmo_cnt    <= '0;
`endif
        end else if (clear) begin
            // Abort keeps rr and the latched data path registers.
            fsm        <= S_IDLE;
            data_break <= 1'b0;
            to_disk    <= 1'b0;
            done       <= '0;
`ifdef DB_TIMEOUT_EN
            err_q      <= '0;
`endif
        end else begin
            done <= '0;
`ifdef DB_TIMEOUT_EN
            err_q <= '0;
`endif
            case (fsm)
                S_IDLE: begin
                    if (win_vld) begin
                        w          <= win;
                        dmaAddr    <= addr_a[win];
                        dmaDOUT    <= wdata_a[win];
                        to_disk    <= ~req_wr[win];
                        data_break <= 1'b1;
`ifdef DB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                        fsm        <= S_BREQ;
                    end
                end
                S_BREQ: begin
                    if (state == DB1_CODE) begin
                        data_break <= 1'b0;
                        fsm        <= S_CAPT;
                    end
`ifdef DB_TIMEOUT_EN
                    else if (tmo_cnt == TW'(DB_TIMEOUT - 1)) begin
                        data_break <= 1'b0;
                        to_disk    <= 1'b0;
                        err_q      <= NREQ'(1) << w;
                        rr         <= next_idx(w);
                        fsm        <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_CAPT: begin
                    rd_data <= dmaDIN;
                    done    <= NREQ'(1) << w;
                    fsm     <= S_FIN;
                end
                S_FIN: begin
                    rr      <= next_idx(w);
                    to_disk <= 1'b0;
                    fsm     <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_db_arbiter.sv
// tb/tb_db_arbiter.sv - self-checking bench for db_arbiter with a transaction-level reference model
module tb_db_arbiter;
    localparam int         NREQ = 2;
    localparam logic [4:0] DB1  = 5'd0;
    localparam logic [4:0] NDB  = 5'd3;
    localparam int         TMO  = 16;
    localparam int         AW   = NREQ * 15;
    localparam int         DW   = NREQ * 12;

    logic            clk, reset, clear;
    logic [4:0]      state;
    logic [NREQ-1:0] req, req_wr, done, err;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [11:0]     rd_data, dmaDOUT, dmaDIN;
    logic            data_break, to_disk, busy;
    logic [14:0]     dmaAddr;

    db_arbiter #(.NREQ(NREQ), .DB1_CODE(DB1), .DB_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .clear(clear), .state(state),
        .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rd_data(rd_data), .data_break(data_break),
        .to_disk(to_disk), .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT), .dmaDIN(dmaDIN),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one transfer at a time, timed from the edge where DB1 was seen.
    bit              m_active;
    int              m_w, m_rr, m_db1, m_age, e;
    logic [14:0]     m_addr;
    logic [11:0]     m_data, m_rd;
    logic            m_dir;
    logic [NREQ-1:0] m_done, m_err;

    function automatic int pick(input logic [NREQ-1:0] r, input int from);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (from + i) % NREQ;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        e++;
        if (reset) begin
            m_active = 0; m_w = 0; m_rr = 0; m_db1 = -1; m_age = 0;
            m_addr = '0; m_data = '0; m_rd = '0; m_dir = 0; m_done = '0; m_err = '0;
        end else if (clear) begin
            m_active = 0; m_done = '0; m_err = '0;
        end else begin
            m_done = '0; m_err = '0;
            if (!m_active) begin
                if (req != '0) begin
                    m_w = pick(req, m_rr);
                    m_active = 1; m_db1 = -1; m_age = 0;
                    m_addr = req_addr[m_w*15 +: 15];
                    m_data = req_wdata[m_w*12 +: 12];
                    m_dir = ~req_wr[m_w];
                end
            end else if (m_db1 < 0) begin
                if (state == DB1) m_db1 = e;
                else begin
                    m_age++;
`ifdef DB_TIMEOUT_EN
                    if (m_age == TMO) begin
                        m_err = NREQ'(1) << m_w;
                        m_rr = (m_w + 1) % NREQ;
                        m_active = 0;
                    end
`endif
                end
            end else if (e == m_db1 + 1) begin
                m_rd = dmaDIN;
                m_done = NREQ'(1) << m_w;
            end else begin
                m_active = 0;
                m_rr = (m_w + 1) % NREQ;
            end
        end
        #1;
        if (chk_en) begin
            chk("data_break", data_break, m_active && (m_db1 < 0));
            chk("to_disk", to_disk, m_active ? m_dir : 1'b0);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("dmaAddr", dmaAddr, m_addr);
            chk("dmaDOUT", dmaDOUT, m_data);
            chk("rd_data", rd_data, m_rd);
        end
    end

    task automatic wait_break(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_break) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output logic [11:0] rd);
        d = '0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done != '0) begin d = done; rd = rd_data; break; end
        end
    endtask

    task automatic pulse_db1(input logic [11:0] din);
        state = DB1; dmaDIN = din;
        @(negedge clk);
        state = NDB;
    endtask

    bit              ok;
    logic [NREQ-1:0] d, seen;
    logic [11:0]     rd;
    int              k, nb;

    initial begin
        e = 0;
        reset = 1; clear = 0; state = NDB; req = '0; req_wr = '0;
        req_addr = '0; req_wdata = '0; dmaDIN = '0;
        repeat (3) @(negedge clk);
        chk("rst_data_break", data_break, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dmaAddr", dmaAddr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk_en = 1;
        reset = 0;
        @(negedge clk);

        // single write from requester 0
        req_wr = 2'b01; req_addr[0 +: 15] = 15'o12345; req_wdata[0 +: 12] = 12'o7070;
        req = 2'b01;
        @(negedge clk);
        chk("wr_break_next_clk", data_break, 1);
        chk("wr_to_disk", to_disk, 0);
        chk("wr_dmaAddr", dmaAddr, 15'o12345);
        chk("wr_dmaDOUT", dmaDOUT, 12'o7070);
        req_addr[0 +: 15] = 15'o77777; req_wdata[0 +: 12] = 12'o1111;
        repeat (4) @(negedge clk);
        pulse_db1(12'o0);
        chk("wr_done_lat1", done, 0);
        @(negedge clk);
        chk("wr_done_lat2", done, 2'b01);
        req = '0;
        @(negedge clk);
        chk("wr_idle_after", busy, 0);

        // single read from requester 1
        req_wr = 2'b00; req_addr[15 +: 15] = 15'o00200; req = 2'b10;
        wait_break(ok);
        chk("rd_break", ok, 1);
        chk("rd_to_disk", to_disk, 1);
        chk("rd_dmaAddr", dmaAddr, 15'o00200);
        pulse_db1(12'o4321);
        wait_done(d, rd);
        chk("rd_done", d, 2'b10);
        chk("rd_data_at_done", rd, 12'o4321);
        req = '0;
        @(negedge clk);

        // contention: both held for four transfers
        req_wr = 2'b11; req_addr = {15'o40001, 15'o30002}; req = 2'b11;
        k = 0;
        for (int c = 0; c < 100 && k < 4; c++) begin
            @(negedge clk);
            if (done != '0) begin
                chk("grant_order", done, (k % 2 == 0) ? 2'b01 : 2'b10);
                k++;
                if (k == 4) req = '0;
            end
            state = data_break ? DB1 : NDB;
        end
        state = NDB; req = '0;
        chk("contention_count", k, 4);
        repeat (2) @(negedge clk);

        // req dropped during BREQ still completes
        req = 2'b01;
        wait_break(ok);
        chk("drop_break", ok, 1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        pulse_db1(12'o0055);
        @(negedge clk);
        chk("drop_done", done, 2'b01);
        repeat (8) @(negedge clk);
        chk("drop_no_regrant", busy, 0);

        // clear during BREQ
        req = 2'b01;
        wait_break(ok);
        chk("abort_break", ok, 1);
        clear = 1; req = '0;
        @(negedge clk);
        clear = 0;
        chk("abort_data_break", data_break, 0);
        chk("abort_busy", busy, 0);
        seen = done;
        repeat (5) begin @(negedge clk); seen |= done; end
        chk("abort_no_done", seen, 0);
        req_addr[15 +: 15] = 15'o05050; req = 2'b10;
        wait_break(ok);
        chk("abort_new_break", ok, 1);
        chk("abort_new_addr", dmaAddr, 15'o05050);
        pulse_db1(12'o2525);
        wait_done(d, rd);
        chk("abort_new_done", d, 2'b10);
        req = '0;
        @(negedge clk);

        // watchdog: requester 0 never gets DB1, requester 1 pending
        req_addr = {15'o02222, 15'o01111}; req_wr = 2'b01; req = 2'b01;
        wait_break(ok);
        chk("tmo_break", ok, 1);
        req = 2'b11;
`ifdef DB_TIMEOUT_EN
        nb = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (err != '0) break;
            if (data_break) nb++;
        end
        chk("tmo_breq_cycles", nb, TMO);
        chk("tmo_err", err, 2'b01);
        chk("tmo_no_done", done, 0);
        chk("tmo_data_break", data_break, 0);
        req = 2'b10;
        wait_break(ok);
        chk("tmo_next_break", ok, 1);
        chk("tmo_next_addr", dmaAddr, 15'o02222);
        pulse_db1(12'o0707);
        wait_done(d, rd);
        chk("tmo_next_done", d, 2'b10);
        req = '0;
`else
        nb = 0;
        repeat (40) begin @(negedge clk); if (data_break) nb++; end
        chk("no_tmo_break_held", nb, 40);
        chk("no_tmo_err", err, 0);
        clear = 1; req = '0;
        @(negedge clk);
        clear = 0;
`endif
        repeat (2) @(negedge clk);

        // asynchronous reset in mid-transfer
        req = 2'b01;
        wait_break(ok);
        chk("areset_break", ok, 1);
        #2 reset = 1;
        #1;
        chk("areset_data_break", data_break, 0);
        chk("areset_busy", busy, 0);
        chk("areset_dmaAddr", dmaAddr, 0);
        @(negedge clk);
        reset = 0; req = '0;
        @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (done[i] || err[i])) req[i] = 1'b0;
                else if (req[i] && busy && $urandom_range(0, 40) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_wr[i] = 1'($urandom_range(0, 1));
                end
            end
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            state  = ($urandom_range(0, 2) == 0) ? DB1 : 5'($urandom_range(1, 31));
            dmaDIN = 12'($urandom);
            clear  = ($urandom_range(0, 99) == 0);
        end
        clear = 0; req = '0; state = NDB;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Shares the CPU data-break (DMA) channel between up to NREQ peripheral DMA engines, such as the RK8E SD disk controller and a future second mass-storage or serial DMA device.
- Sequences each transfer: latches the winner's address, data and direction, raises data_break, waits for the CPU's DB1 state, then returns read data and a done pulse.
- Sits between the peripheral DMA ports and the CPU's data_break/to_disk/dmaAddr/dmaDIN/dmaDOUT interface.

Parameters:
- NREQ, 2: number of requesters, 2..4.
- DB1_CODE, 5'd0: CPU major-state encoding of DB1; must equal the DB1 value in parameters.v.
- DB_TIMEOUT, 1023: watchdog limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous IOCLR/CAF abort.
- state  in  5  CPU major state.
- req  in  NREQ  per-requester transfer request, level.
- req_wr  in  NREQ  1 = write to memory (device to memory), 0 = read.
- req_addr  in  NREQ*15  packed 15-bit memory addresses [0:14].
- req_wdata  in  NREQ*12  packed 12-bit write data [0:11].
- done  out  NREQ  one-cycle completion pulse, one-hot.
- err  out  NREQ  one-cycle timeout pulse, one-hot; stuck at 0 without the optional feature.
- rd_data  out  12  read data, valid while done is asserted and held until the next capture.
- data_break  out  1  data-break request to the CPU.
- to_disk  out  1  direction to the CPU, 1 = memory read (data toward the device).
- dmaAddr  out  15  latched break address.
- dmaDOUT  out  12  latched write data.
- dmaDIN  in  12  memory data from the CPU.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (async) values:
  - All outputs 0, FSM = IDLE.
  - Round-robin pointer rr = 0.
- FSM states: IDLE, BREQ, CAPT, FIN.
- IDLE:
  - If any req bit is set, pick the winner by round robin: the first set bit scanning from rr upward, wrapping modulo NREQ.
  - Latch winner index w, its address into dmaAddr, its data into dmaDOUT, and to_disk = ~req_wr[w].
  - Set data_break = 1 and go to BREQ.
  - Arbitration takes 1 clock: req sampled in cycle n gives data_break = 1 in cycle n+1.
- BREQ:
  - Hold data_break and the latched values until state == DB1_CODE.
  - In that cycle set data_break = 0 and go to CAPT.
- CAPT: rd_data <= dmaDIN; go to FIN.
- FIN:
  - done[w] = 1 for exactly this cycle.
  - rr <= (w+1) mod NREQ.
  - to_disk <= 0, go to IDLE.
  - A re-request is arbitrated no earlier than the next cycle, so there are 3 or more clocks between successive breaks.
- End-to-end latency: done is asserted 2 clocks after the DB1 cycle.
- Requester rules:
  - A requester holds req until its done or err pulse.
  - Dropping req while the FSM is in BREQ/CAPT/FIN does not abort the transfer; the done pulse still fires.
  - Changing req_addr or req_wdata after latching has no effect.
- Simultaneous requests: only one winner per arbitration; losers wait. With rr=0 and req=2'b11, requester 0 wins first and requester 1 next. No requester waits more than NREQ-1 transfers.
- DB1 seen in IDLE (another source, e.g. front panel): ignored.
- clear = 1 (synchronous, highest priority after reset):
  - FSM goes to IDLE; data_break, to_disk, done and err go to 0.
  - rr is kept; rd_data, dmaAddr and dmaDOUT keep their values.
  - No done pulse for the aborted transfer.
- Async reset in mid-operation: immediate return to reset values, including data_break = 0.
- The index widths of w and rr are $clog2(NREQ); values are never outside 0..NREQ-1.

Optional Feature:
- Macro: DB_TIMEOUT_EN.
- Defined:
  - A 10+ bit counter clears on entry to BREQ and increments each BREQ cycle.
  - If it reaches DB_TIMEOUT before DB1 arrives: data_break = 0, err[w] pulses for 1 cycle (no done), rr advances, and the FSM returns to IDLE.
  - DB1 in the same cycle as the limit is reached counts as success.
- Undefined: no counter; BREQ waits indefinitely and err is tied to 0.

Test Plan:
- Single write: req=01, req_wr=1, addr=15'o12345, wdata=12'o7070.
  - data_break rises next clock; to_disk=0, dmaAddr=12345, dmaDOUT=7070.
  - DB1 after 5 clocks, then done[0] pulses 2 clocks later.
- Single read: req=10, req_wr=0, addr=15'o00200; DB1 with dmaDIN=12'o4321.
  - to_disk=1, rd_data=4321 while done[1]=1.
- Contention: both requests held continuously for 4 transfers.
  - Grant order 0,1,0,1; each done is one-hot; data_break drops between transfers.
- Drop req mid-transfer: req[0] deasserted in BREQ.
  - The transfer still completes with done[0]; no further grant.
- Abort: clear during BREQ.
  - Next clock: data_break=0, busy=0, no done; a new request is then serviced normally.
- Timeout (DB_TIMEOUT_EN, DB_TIMEOUT=16): no DB1.
  - err[0] pulses after 16 BREQ cycles, data_break=0, a pending req[1] is serviced next.
  - Without the macro, data_break stays high.
